// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register: operation modes and serialiser states.
package universal_shift_register_pkg;

   localparam int MODE_WIDTH = 3;

   // Encodings 6 and 7 are unused and decode to HOLD.
   typedef enum logic [MODE_WIDTH-1:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_SHR  = 3'd3,
      MODE_ROL  = 3'd4,
      MODE_ROR  = 3'd5
   } mode_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_SERIALIZE = 1'b1
   } state_e;

endpackage

// File: rtl/shift_register_next_value.sv
// Combinational next-value function of the shift register for a given mode and fill bit.
module shift_register_next_value
   import universal_shift_register_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] reg_i,
   input  logic [DATA_WIDTH-1:0] load_i,
   input  mode_e                 mode_i,
   input  logic                  fill_i,
   output logic [DATA_WIDTH-1:0] next_o
);

   always_comb begin
      next_o = reg_i;
      case (mode_i)
         MODE_HOLD: next_o = reg_i;
         MODE_LOAD: next_o = load_i;
         MODE_SHL:  next_o = {reg_i[DATA_WIDTH-2:0], fill_i};
         MODE_SHR:  next_o = {fill_i, reg_i[DATA_WIDTH-1:1]};
         MODE_ROL:  next_o = {reg_i[DATA_WIDTH-2:0], reg_i[DATA_WIDTH-1]};
         MODE_ROR:  next_o = {reg_i[0], reg_i[DATA_WIDTH-1:1]};
         default:   next_o = reg_i;
      endcase
   end

endmodule

// File: rtl/universal_shift_register_n_bit.sv
// N-bit universal shift register with an LSB-first serialiser (Busy/Done handshake).
module universal_shift_register_n_bit
   import universal_shift_register_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Enable_In,
   input  logic [MODE_WIDTH-1:0] Mode_In,
   input  logic                  Serial_Data_In,
   input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
   input  logic                  Start_Serialize_In,
   output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
   output logic                  Serial_Left_Out,
   output logic                  Serial_Right_Out,
   output logic                  Busy_Out,
   output logic                  Done_Out
);

   localparam int COUNT_WIDTH = $clog2(DATA_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0]  shift_q;
   logic [DATA_WIDTH-1:0]  shift_d;
   logic [DATA_WIDTH-1:0]  nxt_value;
   logic [COUNT_WIDTH-1:0] cnt_q;
   state_e                 state_q;
   logic                   busy_q;
   logic                   done_q;
   mode_e                  mode_sel;
   logic                   start_acc;

   // The serialiser reuses the SHR path; Mode_In is ignored while busy.
   always_comb begin
      mode_sel  = (state_q == ST_SERIALIZE) ? MODE_SHR : mode_e'(Mode_In);
      start_acc = (state_q == ST_IDLE) && Start_Serialize_In;
      shift_d   = start_acc ? Parallel_Data_In : nxt_value;
   end

   shift_register_next_value #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_next (
      .reg_i  (shift_q),
      .load_i (Parallel_Data_In),
      .mode_i (mode_sel),
      .fill_i (Serial_Data_In),
      .next_o (nxt_value)
   );

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         shift_q <= '0;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (!Enable_In) begin
         done_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_acc) begin
                  state_q <= ST_SERIALIZE;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            ST_SERIALIZE: begin
               if (cnt_q == LAST_CNT) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Parallel_Data_Out = Enable_In ? shift_q : {DATA_WIDTH{1'bz}};
   assign Serial_Left_Out   = shift_q[DATA_WIDTH-1];
   assign Serial_Right_Out  = shift_q[0];
   assign Busy_Out          = busy_q;
   assign Done_Out          = done_q & Enable_In;

endmodule

// File: tb/tb_universal_shift_register_n_bit.sv
// Bench for universal_shift_register_n_bit (W=8): mode vector table plus serialiser sequences.
module tb_universal_shift_register_n_bit;

   localparam int W = 8;

   typedef struct {
      logic         rst;
      logic         en;
      logic [2:0]   mode;
      logic         sdi;
      logic [W-1:0] pdi;
      logic         start;
      logic [W-1:0] e_reg;
      logic         e_busy;
      logic         e_done;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst, en, sdi, start;
   logic [2:0]   mode;
   logic [W-1:0] pdi;
   wire  [W-1:0] pdo;
   logic         slo, sro, busy, done;

   int n_chk  = 0;
   int n_fail = 0;
   vec_t exp_q[$];

   universal_shift_register_n_bit #(.DATA_WIDTH(W)) dut (
      .Clk_In             (clk),
      .Reset_In           (rst),
      .Enable_In          (en),
      .Mode_In            (mode),
      .Serial_Data_In     (sdi),
      .Parallel_Data_In   (pdi),
      .Start_Serialize_In (start),
      .Parallel_Data_Out  (pdo),
      .Serial_Left_Out    (slo),
      .Serial_Right_Out   (sro),
      .Busy_Out           (busy),
      .Done_Out           (done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic s, logic [W-1:0] p,
                               logic st, logic [W-1:0] er, logic eb, logic ed);
      vec_t v;
      v.rst = r; v.en = e; v.mode = m; v.sdi = s; v.pdi = p; v.start = st;
      v.e_reg = er; v.e_busy = eb; v.e_done = ed;
      return v;
   endfunction

   // Word after i SHR steps with a constant fill bit.
   function automatic logic [W-1:0] shr_fill(logic [W-1:0] w, int i, logic f);
      logic [W-1:0] r = w;
      for (int k = 0; k < i; k++) r = {f, r[W-1:1]};
      return r;
   endfunction

   task automatic chk(string name, int step, logic [W-1:0] act, logic [W-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", name, step, act, req);
      end
   endtask

   int step_no = 0;
   int busy_cycles = 0;

   // Drive one cycle of stimulus, push its expectation, compare after the edge.
   task automatic step(vec_t v);
      vec_t e;
      rst = v.rst; en = v.en; mode = v.mode; sdi = v.sdi; pdi = v.pdi; start = v.start;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      step_no++;
      if (e.en) chk("parallel_out", step_no, pdo, e.e_reg);
      chk("serial_right", step_no, {{(W-1){1'b0}}, sro}, {{(W-1){1'b0}}, e.e_reg[0]});
      chk("serial_left",  step_no, {{(W-1){1'b0}}, slo}, {{(W-1){1'b0}}, e.e_reg[W-1]});
      chk("busy",         step_no, {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, e.e_busy});
      chk("done",         step_no, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e.e_done});
      if (busy) busy_cycles++;
   endtask

   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                          ROL = 3'd4, ROR = 3'd5;

   initial begin
      vec_t tbl[$];
      logic [W-1:0] w;
      logic [W-1:0] r;

      rst = 1'b1; en = 1'b1; mode = HOLD; sdi = 1'b0; pdi = '0; start = 1'b0;

      // Reset, output enable and the shift/rotate modes.
      tbl.push_back(mk(1, 1, HOLD, 0, 8'h00, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'hA5, 0, 8'hA5, 0, 0));
      tbl.push_back(mk(1, 1, LOAD, 0, 8'hFF, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'h3C, 0, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 0, LOAD, 1, 8'hFF, 0, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 0, SHL,  1, 8'hFF, 1, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 1, HOLD, 1, 8'hFF, 0, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'h81, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, ROL,  1, 8'h00, 0, 8'h03, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'h81, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, ROR,  0, 8'h00, 0, 8'hC0, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'h81, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, SHL,  0, 8'h00, 0, 8'h02, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'h81, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, SHR,  1, 8'h00, 0, 8'hC0, 0, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 8'h00, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 8'h81, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, 3'd6, 1, 8'h00, 0, 8'h81, 0, 0));
      tbl.push_back(mk(0, 1, 3'd7, 1, 8'h00, 0, 8'h81, 0, 0));
      foreach (tbl[i]) step(tbl[i]);

      // Serialise 0xB4 with fill 0; mode and a second start are ignored while busy.
      w = 8'hB4;
      busy_cycles = 0;
      step(mk(0, 1, SHL, 0, w, 1, w, 1, 0));
      for (int i = 1; i < W; i++)
         step(mk(0, 1, ROL, 0, 8'h5A, (i == 3), shr_fill(w, i, 0), 1, 0));
      step(mk(0, 1, LOAD, 0, 8'hFF, 0, 8'h00, 0, 1));
      step(mk(0, 1, HOLD, 0, 8'hFF, 0, 8'h00, 0, 0));
      chk("busy_len_8", step_no, W'(busy_cycles), W'(8));

      // Pause 3 cycles after the third shift; fill 1.
      w = 8'h5A;
      busy_cycles = 0;
      step(mk(0, 1, HOLD, 1, w, 1, w, 1, 0));
      for (int i = 1; i <= 3; i++) step(mk(0, 1, HOLD, 1, 8'h00, 0, shr_fill(w, i, 1), 1, 0));
      for (int i = 0; i < 3; i++)  step(mk(0, 0, LOAD, 0, 8'h00, 1, shr_fill(w, 3, 1), 1, 0));
      for (int i = 4; i < W; i++)  step(mk(0, 1, HOLD, 1, 8'h00, 0, shr_fill(w, i, 1), 1, 0));
      step(mk(0, 1, HOLD, 1, 8'h00, 0, 8'hFF, 0, 1));
      step(mk(0, 1, HOLD, 1, 8'h00, 0, 8'hFF, 0, 0));
      chk("busy_len_pause", step_no, W'(busy_cycles), W'(11));

      // Reset while bit 4 is on the output aborts with no Done pulse.
      w = 8'hC3;
      step(mk(0, 1, HOLD, 0, w, 1, w, 1, 0));
      for (int i = 1; i <= 4; i++) step(mk(0, 1, HOLD, 0, 8'h00, 0, shr_fill(w, i, 0), 1, 0));
      step(mk(1, 1, HOLD, 0, 8'h00, 0, 8'h00, 0, 0));
      for (int i = 0; i < 4; i++)  step(mk(0, 1, HOLD, 0, 8'h00, 0, 8'h00, 0, 0));

      // Back-to-back words: second start is driven during the Done cycle.
      busy_cycles = 0;
      w = 8'hF0;
      step(mk(0, 1, HOLD, 0, w, 1, w, 1, 0));
      for (int i = 1; i < W; i++) step(mk(0, 1, HOLD, 0, 8'h00, 0, shr_fill(w, i, 0), 1, 0));
      step(mk(0, 1, HOLD, 0, 8'h00, 0, 8'h00, 0, 1));
      w = 8'h0F;
      step(mk(0, 1, HOLD, 0, w, 1, w, 1, 0));
      for (int i = 1; i < W; i++) step(mk(0, 1, HOLD, 0, 8'h00, 0, shr_fill(w, i, 0), 1, 0));
      step(mk(0, 1, HOLD, 0, 8'h00, 0, 8'h00, 0, 1));
      step(mk(0, 1, HOLD, 0, 8'h00, 0, 8'h00, 0, 0));
      chk("busy_len_b2b", step_no, W'(busy_cycles), W'(16));

      // A load after the serialiser returns to IDLE shows the mode path is live again.
      r = 8'h96;
      step(mk(0, 1, LOAD, 0, r, 0, r, 0, 0));
      step(mk(0, 1, ROR,  0, 8'h00, 0, {r[0], r[W-1:1]}, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/universal_shift_register_n_bit.md
Name: universal_shift_register_n_bit

Overview:
Parametrised successor to the fixed 4-bit parallel-in/parallel-out register. Adds selectable shift/rotate modes, serial in/out, and an autonomous serialiser. The serialiser loads a word and shifts it out LSB-first with Busy/Done handshaking. The block sits between parallel datapaths and bit-serial links, and also serves as a general-purpose shift element.

Parameters:
DATA_WIDTH, 8, register width in bits; legal range is 2 or more.
COUNT_WIDTH, $clog2(DATA_WIDTH), width of the internal shift counter; derived localparam, not overridable.

Ports:
Clk_In  input  1  single clock; all state updates on the rising edge.
Reset_In  input  1  synchronous, active-high reset.
Enable_In  input  1  clock-enable for all state; also the output-enable for Parallel_Data_Out.
Mode_In  input  3  operation select (see Behaviour); ignored while Busy_Out=1.
Serial_Data_In  input  1  fill bit for shift-left, shift-right and serialise.
Parallel_Data_In  input  DATA_WIDTH  load word for mode LOAD and for serialiser start.
Start_Serialize_In  input  1  request to start a serialise operation; sampled only in IDLE.
Parallel_Data_Out  output  DATA_WIDTH  register contents; high-Z when Enable_In=0.
Serial_Left_Out  output  1  register MSB.
Serial_Right_Out  output  1  register LSB; carries the serial stream.
Busy_Out  output  1  high while the serialiser is active.
Done_Out  output  1  one-cycle pulse when serialisation completes.

Behaviour:
- Reset (Reset_In=1 at an edge; priority over everything):
  - r_Shift_Register=0, FSM=IDLE, counter=0, Busy_Out=0, Done_Out=0.
  - Applies mid-serialisation too; the operation is aborted and no Done_Out pulse is issued.
- Enable_In=0:
  - All state holds: register, FSM, counter.
  - Done_Out is forced to 0.
  - Parallel_Data_Out='Z; serial outputs, Busy_Out and Done_Out remain driven.
- Parallel_Data_Out is combinational from the register plus Enable_In, so it updates in the cycle after the edge (zero extra latency).
- FSM states: IDLE, SERIALIZE.
- IDLE, Enable_In=1:
  - If Start_Serialize_In=1, serialise start wins over Mode_In: reg<=Parallel_Data_In, counter<=0, go to SERIALIZE.
  - Otherwise Mode_In applies:
    - 0 HOLD: register unchanged.
    - 1 LOAD: reg<=Parallel_Data_In.
    - 2 SHL: reg<={reg[W-2:0], Serial_Data_In}.
    - 3 SHR: reg<={Serial_Data_In, reg[W-1:1]}.
    - 4 ROL: reg<={reg[W-2:0], reg[W-1]}.
    - 5 ROR: reg<={reg[0], reg[W-1:1]}.
    - 6, 7: treated as HOLD.
- SERIALIZE, Enable_In=1:
  - Each edge performs SHR using Serial_Data_In as fill, and counter increments.
  - On the edge where counter==DATA_WIDTH-1, go to IDLE and assert Done_Out for the next cycle.
  - Total of DATA_WIDTH shifts.
- Serialise timing, with the start accepted at edge k:
  - Bit i of the loaded word appears on Serial_Right_Out in the cycle after edge k+i, for i=0..W-1.
  - Busy_Out is high for exactly W enabled cycles.
  - Done_Out is high in the cycle after the final shift edge; Busy_Out is already 0 in that cycle.
- Enable_In=0 during SERIALIZE pauses the operation; it resumes without losing bits, so Busy_Out stretches.
- Start_Serialize_In while Busy_Out=1 is ignored (not queued).
- Start_Serialize_In in the cycle Done_Out is high is accepted (FSM is IDLE), so back-to-back words are possible.
- Busy_Out = (state==SERIALIZE); registered, so it is glitch-free.

Decomposition:
- Package universal_shift_register_pkg holds:
  - the mode enum (HOLD, LOAD, SHL, SHR, ROL, ROR);
  - the FSM state enum (IDLE, SERIALIZE);
  - MODE_WIDTH=3.
- One sub-module is natural: shift_register_next_value, a combinational next-state function of (reg, mode, fill bit). The serialiser FSM reuses it with mode forced to SHR.
- The counter and FSM stay in the top module.

Test Plan:
1. Reset: W=8, LOAD 0xA5, then Reset_In=1 for 1 cycle -> Parallel_Data_Out=0x00, Busy_Out=0, Done_Out=0.
2. Output-enable: load 0x3C, then Enable_In=0 -> Parallel_Data_Out='Z and register holds. Enable_In=1 -> 0x3C reappears unchanged.
3. Modes: W=8, start from 0x81.
   - ROL -> 0x03.
   - ROR from 0x81 -> 0xC0.
   - SHL with Serial_Data_In=0 from 0x81 -> 0x02.
   - SHR with Serial_Data_In=1 from 0x81 -> 0xC0.
   - Mode 6 -> value held.
4. Serialise: W=8, Parallel_Data_In=0xB4, Start pulse, Serial_Data_In=0:
   - Serial_Right_Out sequence 0,0,1,0,1,1,0,1.
   - Busy_Out high for exactly 8 cycles.
   - Done_Out high for 1 cycle.
   - Register ends at 0x00.
5. Pause/abort/overlap:
   - Drop Enable_In for 3 cycles mid-serialise -> stream continues intact; Busy_Out lasts 11 cycles.
   - Separately, Reset_In at bit 4 -> Busy_Out=0 next cycle, no Done_Out.
   - Start while Busy_Out=1 -> ignored.
6. Back-to-back: Start asserted in the Done_Out cycle with 0x0F, after 0xF0 -> 16 contiguous serial bits, and Busy_Out low for only the Done cycle.
